// File: rtl/alu_acc_sequencer.sv
// Accumulator ALU behind a valid/ready command port and a valid/ready response port.
// Each command is accepted in IDLE, executed in EXEC and held in RESP until the consumer takes it.
module alu_acc_sequencer #(
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opcode,
  input  logic [7:0] in_operand,
  input  logic       in_load,
  input  logic       in_use_carry,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_cout,
  output logic       out_zero,
  output logic       out_sign,
  output logic       out_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, next_state;
  logic [2:0] op_q;
  logic [7:0] operand_q;
  logic       load_q, use_carry_q;
  logic [7:0] acc;
  logic       c_flag;
  logic [8:0] sum;
  logic [7:0] res;
  logic       cin, cout, ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == RESP);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtract is A + ~B + cin, so the default carry-in for sub is 1 (no borrow).
  always_comb begin
    cin  = use_carry_q ? c_flag : (op_q == 3'b001);
    sum  = 9'd0;
    res  = acc;
    cout = 1'b0;
    ovf  = 1'b0;
    if (load_q) begin
      res = operand_q;
    end else begin
      case (op_q)
        3'b000: begin
          sum  = {1'b0, acc} + {1'b0, operand_q} + {8'd0, cin};
          res  = sum[7:0];
          cout = sum[8];
          ovf  = (acc[7] == operand_q[7]) && (res[7] != acc[7]);
        end
        3'b001: begin
          sum  = {1'b0, acc} + {1'b0, ~operand_q} + {8'd0, cin};
          res  = sum[7:0];
          cout = sum[8];
          ovf  = (acc[7] != operand_q[7]) && (res[7] != acc[7]);
        end
        3'b010:  res = acc & operand_q;
        3'b011:  res = acc | operand_q;
        3'b100:  res = acc ^ operand_q;
        3'b101:  res = ~acc;
        3'b110:  res = acc + 8'd1;
        default: res = acc - 8'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 3'd0;
      operand_q    <= 8'd0;
      load_q       <= 1'b0;
      use_carry_q  <= 1'b0;
      acc          <= ACC_INIT;
      c_flag       <= 1'b0;
      out_result   <= 8'd0;
      out_cout     <= 1'b0;
      out_zero     <= 1'b0;
      out_sign     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        op_q        <= in_opcode;
        operand_q   <= in_operand;
        load_q      <= in_load;
        use_carry_q <= in_use_carry;
      end
      if (state == EXEC) begin
        acc          <= res;
        out_result   <= res;
        out_cout     <= cout;
        out_zero     <= (res == 8'd0);
        out_sign     <= res[7];
        out_overflow <= ovf;
        // Only arithmetic commands produce a carry; everything else leaves C alone.
        if (!load_q && (op_q == 3'b000 || op_q == 3'b001))
          c_flag <= cout;
      end
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Self-checking bench for alu_acc_sequencer: directed scenarios plus random commands
// compared against an arithmetic reference model of the accumulator and carry flag.
module tb_alu_acc_sequencer;

  localparam logic [7:0] INIT = 8'h3C;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_operand;
  logic       in_load;
  logic       in_use_carry;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_cout;
  logic       out_zero;
  logic       out_sign;
  logic       out_overflow;

  int         checks;
  int         failures;
  logic [7:0] acc_m;
  logic       c_m;

  alu_acc_sequencer #(.ACC_INIT(INIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_operand   (in_operand),
    .in_load      (in_load),
    .in_use_carry (in_use_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_cout     (out_cout),
    .out_zero     (out_zero),
    .out_sign     (out_sign),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic on the architectural accumulator.
  function automatic void model(input logic ld, input logic [2:0] op, input logic [7:0] b,
                                input logic uc, output logic [7:0] r, output logic co,
                                output logic v);
    int a_i, b_i, ci, s, sa, sb, sg;
    a_i = int'(acc_m);
    b_i = int'(b);
    sa  = (a_i > 127) ? a_i - 256 : a_i;
    sb  = (b_i > 127) ? b_i - 256 : b_i;
    co  = 1'b0;
    v   = 1'b0;
    if (ld) begin
      r = b;
    end else if (op == 3'd0) begin
      ci = uc ? int'(c_m) : 0;
      s  = a_i + b_i + ci;
      sg = sa + sb + ci;
      r  = 8'(s % 256);
      co = (s > 255);
      v  = (sg > 127) || (sg < -128);
      c_m = co;
    end else if (op == 3'd1) begin
      ci = uc ? int'(c_m) : 1;
      s  = a_i + (255 - b_i) + ci;
      sg = sa - sb - 1 + ci;
      r  = 8'(s % 256);
      co = (s > 255);
      v  = (sg > 127) || (sg < -128);
      c_m = co;
    end else begin
      case (op)
        3'd2:    r = 8'(a_i & b_i);
        3'd3:    r = 8'(a_i | b_i);
        3'd4:    r = 8'(a_i ^ b_i);
        3'd5:    r = 8'(255 - a_i);
        3'd6:    r = 8'((a_i + 1) % 256);
        default: r = 8'((a_i + 255) % 256);
      endcase
    end
    acc_m = r;
  endfunction

  task automatic applyStimulus(input logic ld, input logic [2:0] op, input logic [7:0] b,
                               input logic uc, input int stall);
    logic [7:0] er;
    logic       eco, ev;
    int         n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_cmd", in_ready, 1);
    in_valid     = 1'b1;
    in_load      = ld;
    in_opcode    = op;
    in_operand   = b;
    in_use_carry = uc;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_load      = 1'($urandom);
    in_opcode    = 3'($urandom);
    in_operand   = 8'($urandom);
    in_use_carry = 1'($urandom);
    checkOutput("exec_in_ready", in_ready, 0);
    checkOutput("exec_out_valid", out_valid, 0);
    model(ld, op, b, uc, er, eco, ev);
    @(posedge clk);
    #1;
    checkOutput("latency_out_valid", out_valid, 1);
    checkOutput("result", out_result, er);
    checkOutput("cout", out_cout, eco);
    checkOutput("zero", out_zero, (er == 8'd0));
    checkOutput("sign", out_sign, er[7]);
    checkOutput("overflow", out_overflow, ev);
    for (int i = 0; i < stall; i++) begin
      in_valid   = 1'b1;
      in_opcode  = 3'($urandom);
      in_operand = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_result", out_result, er);
      checkOutput("stall_flags", {out_cout, out_zero, out_sign, out_overflow},
                  {eco, (er == 8'd0), er[7], ev});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("handshake_out_valid", out_valid, 0);
    checkOutput("handshake_in_ready", in_ready, 1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    acc_m        = INIT;
    c_m          = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_opcode    = 3'd0;
    in_operand   = 8'd0;
    in_load      = 1'b0;
    in_use_carry = 1'b0;
    out_ready    = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", out_result, 0);
    checkOutput("reset_flags", {out_cout, out_zero, out_sign, out_overflow}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_first_edge", in_ready, 1);

    $display("[TB] accumulator init value");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 0);

    $display("[TB] signed overflow on add");
    applyStimulus(1'b1, 3'd0, 8'h7F, 1'b0, 0);
    applyStimulus(1'b0, 3'd0, 8'h01, 1'b0, 0);

    $display("[TB] carry chain");
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0, 0);
    applyStimulus(1'b0, 3'd0, 8'h01, 1'b0, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 0);

    $display("[TB] subtract");
    applyStimulus(1'b1, 3'd0, 8'h05, 1'b0, 0);
    applyStimulus(1'b0, 3'd1, 8'h05, 1'b0, 0);
    applyStimulus(1'b1, 3'd0, 8'h80, 1'b0, 0);
    applyStimulus(1'b0, 3'd1, 8'h01, 1'b0, 0);

    $display("[TB] wrap-around increment and decrement");
    applyStimulus(1'b1, 3'd0, 8'h00, 1'b0, 0);
    applyStimulus(1'b0, 3'd7, 8'h00, 1'b0, 0);
    applyStimulus(1'b0, 3'd6, 8'h00, 1'b0, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 0);

    $display("[TB] response stall with pending input");
    applyStimulus(1'b1, 3'd0, 8'h12, 1'b0, 5);
    applyStimulus(1'b0, 3'd0, 8'h01, 1'b0, 0);

    $display("[TB] random commands");
    for (int k = 0; k < 40; k++)
      applyStimulus(1'($urandom_range(0, 5) == 0), 3'($urandom), 8'($urandom),
                    1'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] reset during execution");
    applyStimulus(1'b1, 3'd0, 8'hA5, 1'b0, 0);
    in_valid     = 1'b1;
    in_load      = 1'b0;
    in_opcode    = 3'd0;
    in_operand   = 8'h11;
    in_use_carry = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midexec_reset_out_valid", out_valid, 0);
    checkOutput("midexec_reset_in_ready", in_ready, 0);
    checkOutput("midexec_reset_result", out_result, 0);
    checkOutput("midexec_reset_flags", {out_cout, out_zero, out_sign, out_overflow}, 0);
    in_valid = 1'b0;
    acc_m    = INIT;
    c_m      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("no_response_for_discarded", out_valid, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
ALU_ACC_SEQUENCER -- requirements
Module: alu_acc_sequencer

Interface
REQ-001 SHALL have parameter ACC_INIT, default 8'h00, value loaded into the accumulator at reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port in_opcode  input  3  operation code, encoding per REQ-013.
REQ-007 SHALL have port in_operand  input  8  operand B.
REQ-008 SHALL have port in_load  input  1  1 = load in_operand into the accumulator; in_opcode is ignored.
REQ-009 SHALL have port in_use_carry  input  1  1 = carry-in is the stored C flag; 0 = carry-in is the value in REQ-014.
REQ-010 SHALL have port out_valid  output  1  response present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the response.
REQ-012 SHALL have ports out_result (output, 8), out_cout, out_zero, out_sign and out_overflow (each output, 1): the result and the flags after the command.

Function
REQ-013 Opcodes SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A+1, 111 A-1. Operand A is always the accumulator (ACC).
REQ-014 Carry-in SHALL be: stored C if in_use_carry=1; otherwise 0 for add and 1 for sub.
REQ-015 add SHALL compute {cout,res} = A + B + cin, 9-bit.
REQ-016 sub SHALL compute {cout,res} = A + ~B + cin, 9-bit; cout=1 means no borrow.
REQ-017 The remaining opcodes SHALL compute res modulo 256 (FF+1 gives 00, 00-1 gives FF). cout SHALL be 0 and C SHALL keep its previous value.
REQ-018 Overflow SHALL be computed for add and sub only:
- add: A[7]==B[7] and res[7]!=A[7]
- sub: A[7]!=B[7] and res[7]!=A[7]
- all other opcodes and load: V = 0.
REQ-019 For every command: Z = (res==0) and N = res[7]. Load SHALL set res = in_operand, clear V and keep C.
REQ-020 The FSM SHALL have three states: IDLE, EXEC, RESP.
- IDLE: in_ready=1; in_valid&&in_ready at an edge latches opcode, operand, load and use_carry, then goes to EXEC.
- EXEC: in_ready=0; at the next edge ACC<=res, flags C/Z/N/V update, outputs are registered, and the FSM goes to RESP.
- RESP: out_valid=1; outputs held stable until out_valid&&out_ready at an edge, then IDLE.
REQ-021 Latency SHALL be exactly 2 edges from acceptance to out_valid=1. Throughput SHALL be at most one command per 3 cycles with out_ready held high.
REQ-022 in_ready SHALL be 0 in EXEC and RESP. in_valid and input data in those states SHALL be ignored, with no state change.
REQ-023 out_valid SHALL be 0 in IDLE and EXEC. A stall in RESP (out_ready=0) SHALL hold all out_* values and ACC unchanged for any number of cycles.
REQ-024 The stored C used by in_use_carry SHALL be the value left by the previous completed command.
REQ-025 in_ready and out_valid SHALL be registered outputs, driven directly from state decode only, with no combinational path from in_valid or out_ready.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, ACC=ACC_INIT, C=Z=N=V=0
- out_result=0, out_cout=out_zero=out_sign=out_overflow=0, out_valid=0
- in_ready=0 while rst_n=0.
REQ-027 Reset during EXEC or RESP SHALL discard the command in flight; no response is issued for it.
REQ-028 in_ready SHALL rise at the first clk edge after rst_n deasserts.

Verification
REQ-029 Load 8'h7F, then add 8'h01 with use_carry=0 -> out_result=80, cout=0, zero=0, sign=1, overflow=1; out_valid exactly 2 edges after acceptance.
REQ-030 Load FF, add 01 (use_carry=0), then add 00 with use_carry=1 -> first response 00/cout=1/zero=1; second response 01/cout=0.
REQ-031 Load 05, sub 05 (use_carry=0) -> 00, cout=1, zero=1, overflow=0. Load 80, sub 01 -> 7F, cout=1, overflow=1.
REQ-032 Load 00, opcode 111 -> FF, sign=1, cout=0, C unchanged. Then opcode 110 -> 00, zero=1.
REQ-033 Hold out_ready=0 for 5 cycles in RESP while driving in_valid=1 with new data -> in_ready=0 throughout, outputs stable, second command accepted only after the response handshake.
REQ-034 Assert rst_n=0 mid-EXEC -> out_valid=0 with no clk edge needed, ACC=ACC_INIT, flags 0; next command executes against ACC_INIT.
